conv_stream_engine: RTL and testbench
=====================================

CONV_STREAM_ENGINE -- requirements
Module: conv_stream_engine

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning signed pixel/weight width.
REQ-002 The block SHALL have parameter KSIZE, default 3, meaning kernel edge; one window is KSIZE*KSIZE taps.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 16, meaning input buffer entries, a power of two and at least 2.
REQ-004 The block SHALL have parameter OUT_W, default 2*DATA_W, meaning result width; internal ACC_W = 2*DATA_W + clog2(KSIZE*KSIZE).
REQ-005 The block SHALL have port Clk, input, 1, the single clock; every flop is on its rising edge.
REQ-006 The block SHALL have port Rst, input, 1, reset, synchronous and active-high.
REQ-007 The block SHALL have port in_valid, input, 1, meaning the write request for one tap.
REQ-008 The block SHALL have port in_data, input, 2*DATA_W, carrying {pixel[DATA_W-1:0], weight[DATA_W-1:0]}, both signed.
REQ-009 The block SHALL have port in_ready, output, 1, equal to ~FULL.
REQ-010 The block SHALL have port cStart, input, 1, a one-cycle window start pulse.
REQ-011 The block SHALL have port sat_en, input, 1, selecting output overflow handling: 1 saturates, 0 wraps; sampled with cStart.
REQ-012 The block SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, OUT_W), forming the result handshake.
REQ-013 The block SHALL have port sat_flag, output, 1, set when the current result overflowed OUT_W.
REQ-014 The block SHALL have ports FULL, EMPTY and busy, output, 1 each; they are the FIFO status and engine-not-IDLE.

Function
REQ-015 The input FIFO SHALL accept a tap on every cycle with in_valid & ~FULL; a write while FULL is dropped and does not change state.
REQ-016 The FIFO SHALL be show-ahead and SHALL use read/write pointers one bit wider than log2(FIFO_DEPTH), so wrap-around is exact.
REQ-017 A simultaneous push and pop SHALL leave the occupancy unchanged; a pop is never issued while EMPTY.
REQ-018 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE.
REQ-019 In IDLE, cStart SHALL clear the accumulator, tap counter and sat_flag, latch sat_en and enter RUN; cStart in any other state SHALL be ignored.
REQ-020 In RUN, the engine SHALL pop one tap per cycle whenever ~EMPTY and SHALL stall without error when EMPTY.
REQ-021 Each popped pair SHALL be multiplied signed into a registered product, with full 2*DATA_W width and no truncation.
REQ-022 The product SHALL be added to the ACC_W accumulator on the following cycle.
REQ-023 After the KSIZE*KSIZE-th pop, the FSM SHALL enter DRAIN.
REQ-024 out_valid SHALL rise exactly 2 cycles after the final pop, and the FSM SHALL then be in DONE.
REQ-025 Output conversion SHALL work as follows: if the accumulator is outside the signed OUT_W range, sat_en=1 clamps to max/min and sets sat_flag; sat_en=0 emits the low OUT_W bits and still sets sat_flag.
REQ-026 In DONE, out_data and sat_flag SHALL hold stable until out_valid & out_ready, then the FSM SHALL return to IDLE on the next edge.
REQ-027 The FIFO SHALL keep accepting writes in every state, so the next window can be prefilled during DONE.
REQ-028 out_data SHALL read 0 whenever out_valid=0.

Reset
REQ-029 Rst SHALL reset the block on the rising edge of Clk: FSM=IDLE, pointers=0, accumulator=0, out_valid=0, out_data=0, sat_flag=0, busy=0, EMPTY=1, FULL=0, in_ready=1.
REQ-030 Rst asserted mid-window SHALL discard the partial sum and all FIFO contents, and no out_valid SHALL follow.
REQ-031 Rst SHALL take priority over cStart and in_valid in the same cycle.

Structure
REQ-032 The parameter defaults, state encoding and the clog2 helper SHALL reside in shared package conv_pkg.
REQ-033 The FIFO SHALL be the single sub-module sync_fifo, parametrised by width and depth; the FSM, MAC and output stage SHALL be in conv_stream_engine.

Verification
REQ-034 With DATA_W=8 and KSIZE=3, 9 taps of (2,3) followed by cStart SHALL produce out_data=54 and sat_flag=0, with out_valid 2 cycles after the 9th pop.
REQ-035 With sat_en=1 and OUT_W=16, 9 taps of (-128,-128) SHALL produce out_data=32767 and sat_flag=1; with sat_en=0 they SHALL produce out_data=16384 and sat_flag=1.
REQ-036 If cStart is issued with the FIFO empty and taps then arrive at one per 3 cycles, the engine SHALL stall in RUN and produce the correct sum, and busy SHALL stay high throughout.
REQ-037 With FIFO_DEPTH=16, pushing 20 taps with no pops SHALL give FULL after 16, in_ready=0, and entries 17-20 dropped; a push and pop in the same cycle at 15 entries SHALL leave the occupancy at 15.
REQ-038 Rst asserted after 5 pops SHALL give EMPTY=1, out_valid never asserting, and a following clean window returning the correct sum.
REQ-039 With out_ready held at 0 for 10 cycles in DONE, out_data SHALL stay stable; cStart pulsed during DONE SHALL be ignored, and the next window SHALL start only from IDLE.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the streaming convolution engine.
// Holds parameter defaults, the FSM state encoding and a ceil-log2 helper.
package conv_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int KSIZE_DEF      = 3;
  localparam int FIFO_DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with extra-bit pointers for exact full/empty.
// Writes while full and reads while empty are ignored.
module sync_fifo
  import conv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/conv_stream_engine.sv
// Streaming KSIZE x KSIZE multiply-accumulate engine fed by an input tap FIFO.
//   state | meaning
//   IDLE  | waiting for cStart; FIFO may prefill
//   RUN   | popping taps, stalls while FIFO empty
//   DRAIN | last product being accumulated
//   DONE  | result presented until out_ready
module conv_stream_engine
  import conv_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int KSIZE      = KSIZE_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int OUT_W      = 2*DATA_W
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                in_valid,
  input  logic [2*DATA_W-1:0] in_data,
  output logic                in_ready,
  input  logic                cStart,
  input  logic                sat_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_data,
  output logic                sat_flag,
  output logic                FULL,
  output logic                EMPTY,
  output logic                busy
);

  localparam int NTAPS = KSIZE*KSIZE;
  localparam int ACC_W = 2*DATA_W + clog2(NTAPS);
  localparam int CNT_W = clog2(NTAPS+1);

  state_t                      state, next_state;
  logic [2*DATA_W-1:0]         tap;
  logic signed [DATA_W-1:0]    pixel, weight;
  logic signed [2*DATA_W-1:0]  prod;
  logic signed [ACC_W-1:0]     prod_ext, acc;
  logic [CNT_W-1:0]            tap_cnt;
  logic                        prod_vld, sat_mode, pop, last_pop, ovf;
  logic [OUT_W-1:0]            conv;

  sync_fifo #(.WIDTH(2*DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(Clk), .rst(Rst), .push(in_valid), .pop(pop),
    .din(in_data), .dout(tap), .full(FULL), .empty(EMPTY)
  );

  assign in_ready = ~FULL;
  assign pixel    = tap[2*DATA_W-1:DATA_W];
  assign weight   = tap[DATA_W-1:0];
  assign prod_ext = ACC_W'(prod);
  assign last_pop = pop && (tap_cnt == CNT_W'(NTAPS-1));

  always_ff @(posedge Clk) begin
    if (Rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (cStart)    next_state = ST_RUN;
      ST_RUN:   if (last_pop)  next_state = ST_DRAIN;
      ST_DRAIN:                next_state = ST_DONE;
      ST_DONE:  if (out_ready) next_state = ST_IDLE;
      default:                 next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    pop       = (state == ST_RUN) && !EMPTY;
    busy      = (state != ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  // Product is registered on the pop edge and folded into acc one edge later.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      tap_cnt  <= '0;
      prod     <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
      sat_mode <= 1'b0;
    end else if (state == ST_IDLE && cStart) begin
      tap_cnt  <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
      sat_mode <= sat_en;
    end else begin
      prod_vld <= pop;
      if (pop) begin
        prod    <= (2*DATA_W)'(pixel) * (2*DATA_W)'(weight);
        tap_cnt <= tap_cnt + CNT_W'(1);
      end
      if (prod_vld) acc <= acc + prod_ext;
    end
  end

  generate
    if (OUT_W < ACC_W) begin : g_narrow
      logic [ACC_W-OUT_W:0] hi;
      assign hi  = acc[ACC_W-1:OUT_W-1];
      assign ovf = !((&hi) || !(|hi));
      always_comb begin
        conv = acc[OUT_W-1:0];
        if (ovf && sat_mode)
          conv = acc[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      end
    end else begin : g_wide
      assign ovf  = 1'b0;
      assign conv = OUT_W'(acc);
    end
  endgenerate

  assign out_data = out_valid ? conv : '0;
  assign sat_flag = out_valid & ovf;

endmodule

// File: tb/tb_conv_stream_engine.sv
// Directed bench for conv_stream_engine with DATA_W=8, KSIZE=3, FIFO_DEPTH=16, OUT_W=16.
module tb_conv_stream_engine;

  localparam int DW = 8;
  localparam int KS = 3;
  localparam int FD = 16;
  localparam int OW = 16;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [2*DW-1:0] in_data = '0;
  logic          in_ready;
  logic          cStart = 1'b0;
  logic          sat_en = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] out_data;
  logic          sat_flag;
  logic          FULL, EMPTY, busy;
  logic [4:0]    occ;

  int n_chk  = 0;
  int n_pass = 0;

  conv_stream_engine #(.DATA_W(DW), .KSIZE(KS), .FIFO_DEPTH(FD), .OUT_W(OW)) dut (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cStart(cStart), .sat_en(sat_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .sat_flag(sat_flag), .FULL(FULL), .EMPTY(EMPTY), .busy(busy)
  );

  assign occ = dut.u_fifo.wr_ptr - dut.u_fifo.rd_ptr;

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_tap(input logic [7:0] p, input logic [7:0] w);
    in_valid = 1'b1;
    in_data  = {p, w};
    tick();
    in_valid = 1'b0;
  endtask

  task automatic fill(input int n, input logic [7:0] p, input logic [7:0] w);
    for (int i = 0; i < n; i++) push_tap(p, w);
  endtask

  task automatic start_win(input logic se);
    cStart = 1'b1;
    sat_en = se;
    tick();
    cStart = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
  endtask

  initial begin
    int cyc;
    int bad;

    // reset with cStart and in_valid also asserted
    Rst = 1'b1; cStart = 1'b1; in_valid = 1'b1; in_data = 16'h0203;
    tick(); tick();
    Rst = 1'b0; cStart = 1'b0; in_valid = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_sat_flag",  64'(sat_flag),  64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_empty",     64'(EMPTY),     64'd1);
    check("rst_full",      64'(FULL),      64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);

    // 9 x (2,3) = 54, out_valid 10 edges after the start edge
    fill(9, 8'd2, 8'd3);
    start_win(1'b0);
    check("basic_busy", 64'(busy), 64'd1);
    wait_valid("basic", cyc);
    check("basic_latency", 64'(cyc), 64'd10);
    check("basic_data", 64'(out_data), 64'd54);
    check("basic_sat", 64'(sat_flag), 64'd0);
    accept("basic");
    check("basic_data_after", 64'(out_data), 64'd0);

    // positive overflow, saturating
    fill(9, 8'h80, 8'h80);
    start_win(1'b1);
    wait_valid("satp", cyc);
    check("satp_data", 64'(out_data), 64'h7FFF);
    check("satp_flag", 64'(sat_flag), 64'd1);
    accept("satp");

    // negative overflow, saturating: 9 * (-16256)
    fill(9, 8'h80, 8'h7F);
    start_win(1'b1);
    wait_valid("satn", cyc);
    check("satn_data", 64'(out_data), 64'h8000);
    check("satn_flag", 64'(sat_flag), 64'd1);
    accept("satn");

    // positive overflow, wrapping; hold in DONE with cStart pulse and prefill
    fill(9, 8'h80, 8'h80);
    start_win(1'b0);
    wait_valid("wrap", cyc);
    check("wrap_data", 64'(out_data), 64'h4000);
    check("wrap_flag", 64'(sat_flag), 64'd1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      cStart   = (i == 3);
      sat_en   = 1'b1;
      in_valid = (i < 9);
      in_data  = {8'd1, 8'hFF};
      tick();
      if (out_data !== 16'h4000 || out_valid !== 1'b1 || sat_flag !== 1'b1) bad++;
    end
    cStart = 1'b0; in_valid = 1'b0;
    check("hold_stable", 64'(bad), 64'd0);
    accept("hold");
    check("prefill_present", 64'(EMPTY), 64'd0);

    // prefilled window: 9 * (1 * -1) = -9
    start_win(1'b0);
    wait_valid("prefill", cyc);
    check("prefill_data", 64'(out_data), 64'hFFF7);
    check("prefill_sat", 64'(sat_flag), 64'd0);
    accept("prefill");

    // starved window: taps 1 per 3 cycles, sum 2*(1+..+9) = 90
    bad = 0;
    start_win(1'b0);
    for (int i = 1; i <= 9; i++) begin
      push_tap(8'(i), 8'd2);
      if (busy !== 1'b1) bad++;
      tick();
      if (busy !== 1'b1) bad++;
      tick();
      if (busy !== 1'b1) bad++;
    end
    wait_valid("stall", cyc);
    check("stall_busy", 64'(bad), 64'd0);
    check("stall_data", 64'(out_data), 64'd90);
    accept("stall");

    // FIFO full and drop behaviour
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      in_valid = 1'b1;
      in_data  = {8'(i), 8'd1};
      tick();
      if (i == 15) check("full_at15", 64'(FULL), 64'd0);
      if (i == 16) begin
        check("full_at16", 64'(FULL), 64'd1);
        check("full_in_ready", 64'(in_ready), 64'd0);
      end
    end
    in_valid = 1'b0;
    check("full_occ", 64'(occ), 64'd16);
    start_win(1'b0);
    tick();
    check("occ_before_pp", 64'(occ), 64'd15);
    push_tap(8'd50, 8'd1);
    check("occ_after_pp", 64'(occ), 64'd15);
    wait_valid("fifo_w1", cyc);
    check("fifo_w1_data", 64'(out_data), 64'd45);
    accept("fifo_w1");
    push_tap(8'd5, 8'd1);
    start_win(1'b0);
    wait_valid("fifo_w2", cyc);
    check("fifo_w2_data", 64'(out_data), 64'd146);
    accept("fifo_w2");

    // reset mid-window after 5 pops
    fill(9, 8'd7, 8'd7);
    start_win(1'b0);
    repeat (5) tick();
    do_reset();
    check("midrst_empty", 64'(EMPTY), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    bad = 0;
    repeat (12) begin
      tick();
      if (out_valid !== 1'b0) bad++;
    end
    check("midrst_no_valid", 64'(bad), 64'd0);
    fill(9, 8'd3, 8'hFC);
    start_win(1'b0);
    wait_valid("clean", cyc);
    check("clean_data", 64'(out_data), 64'hFF94);
    accept("clean");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
